// File: rtl/quad_velocity.sv
// Gated-window velocity meter: counts signed decoder steps per window, publishes one
// saturating sample per window and flags a shaft that has produced no steps for a while.
module quad_velocity #(
  parameter int WINDOW_CYCLES = 1000,
  parameter int VEL_W         = 16,
  parameter int STALL_WINDOWS = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic                    count_enable,
  input  logic                    count_direction,
  output logic signed [VEL_W-1:0] velocity,
  output logic                    vel_valid,
  output logic                    vel_sat,
  output logic                    stalled
);

  localparam int WC_W = (WINDOW_CYCLES > 1) ? $clog2(WINDOW_CYCLES) : 1;
  localparam int ZC_W = $clog2(STALL_WINDOWS + 1);
  localparam logic [WC_W-1:0]         LAST_WIN = WC_W'(WINDOW_CYCLES - 1);
  localparam logic [ZC_W-1:0]         ZC_MAX   = ZC_W'(STALL_WINDOWS);
  localparam logic signed [VEL_W-1:0] ACC_MAX  = {1'b0, {(VEL_W-1){1'b1}}};
  localparam logic signed [VEL_W-1:0] ACC_MIN  = {1'b1, {(VEL_W-1){1'b0}}};
  localparam logic signed [VEL_W-1:0] ACC_ONE  = {{(VEL_W-1){1'b0}}, 1'b1};

  logic [WC_W-1:0]         r_win_cnt;
  logic signed [VEL_W-1:0] r_acc;
  logic                    r_sat_acc;
  logic                    r_step_seen;
  logic [ZC_W-1:0]         r_zero_cnt;
  logic signed [VEL_W-1:0] r_velocity;
  logic                    r_vel_valid;
  logic                    r_vel_sat;
  logic                    r_stalled;

  logic                    w_step;
  logic                    w_close;
  logic                    w_clamp;
  logic signed [VEL_W-1:0] w_acc_nxt;

  // Next accumulator value including the current step, clamped at the signed limits.
  always_comb begin
    w_step    = enable & count_enable;
    w_close   = enable && (r_win_cnt == LAST_WIN);
    w_clamp   = 1'b0;
    w_acc_nxt = r_acc;
    if (w_step) begin
      if (count_direction) begin
        if (r_acc == ACC_MAX) w_clamp   = 1'b1;
        else                  w_acc_nxt = r_acc + ACC_ONE;
      end else begin
        if (r_acc == ACC_MIN) w_clamp   = 1'b1;
        else                  w_acc_nxt = r_acc - ACC_ONE;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_win_cnt   <= '0;
      r_acc       <= '0;
      r_sat_acc   <= 1'b0;
      r_step_seen <= 1'b0;
      r_zero_cnt  <= '0;
      r_velocity  <= '0;
      r_vel_valid <= 1'b0;
      r_vel_sat   <= 1'b0;
      r_stalled   <= 1'b0;
    end else if (!enable) begin
      r_win_cnt   <= '0;
      r_acc       <= '0;
      r_sat_acc   <= 1'b0;
      r_step_seen <= 1'b0;
      r_vel_valid <= 1'b0;
    end else if (w_close) begin
      r_velocity  <= w_acc_nxt;
      r_vel_sat   <= r_sat_acc | w_clamp;
      r_vel_valid <= 1'b1;
      r_win_cnt   <= '0;
      r_acc       <= '0;
      r_sat_acc   <= 1'b0;
      r_step_seen <= 1'b0;
      if (w_step) begin
        r_zero_cnt <= '0;
        r_stalled  <= 1'b0;
      end else if (!r_step_seen && r_zero_cnt != ZC_MAX) begin
        r_zero_cnt <= r_zero_cnt + 1'b1;
        if (r_zero_cnt + 1'b1 == ZC_MAX) r_stalled <= 1'b1;
      end
    end else begin
      r_win_cnt   <= r_win_cnt + 1'b1;
      r_acc       <= w_acc_nxt;
      r_sat_acc   <= r_sat_acc | w_clamp;
      r_vel_valid <= 1'b0;
      // Any step proves the shaft is moving; clear stall immediately, not at window close.
      if (w_step) begin
        r_step_seen <= 1'b1;
        r_zero_cnt  <= '0;
        r_stalled   <= 1'b0;
      end
    end
  end

  assign velocity  = r_velocity;
  assign vel_valid = r_vel_valid;
  assign vel_sat   = r_vel_sat;
  assign stalled   = r_stalled;

endmodule

// File: tb/tb_quad_velocity.sv
// Directed bench for quad_velocity: an 8-bit and a 3-bit instance share one stimulus stream.
module tb_quad_velocity;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic enable = 1'b0;
  logic ce = 1'b0;
  logic dir = 1'b0;

  logic signed [7:0] vel8;
  logic              val8, sat8, stl8;
  logic signed [2:0] vel3;
  logic              val3, sat3, stl3;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  quad_velocity #(.WINDOW_CYCLES(10), .VEL_W(8), .STALL_WINDOWS(2)) u_dut8 (
    .clk(clk), .reset(reset), .enable(enable), .count_enable(ce), .count_direction(dir),
    .velocity(vel8), .vel_valid(val8), .vel_sat(sat8), .stalled(stl8)
  );

  quad_velocity #(.WINDOW_CYCLES(10), .VEL_W(3), .STALL_WINDOWS(2)) u_dut3 (
    .clk(clk), .reset(reset), .enable(enable), .count_enable(ce), .count_direction(dir),
    .velocity(vel3), .vel_valid(val3), .vel_sat(sat3), .stalled(stl3)
  );

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Inputs change 1ns after a rising edge; outputs are sampled at the same point.
  task automatic tick(input logic c, input logic d);
    ce  = c;
    dir = d;
    @(posedge clk);
    #1;
  endtask

  // One full 10-cycle window; bit i of m/d is the step/direction on win_cnt==i.
  task automatic run_win(input string tag, input logic [9:0] m, input logic [9:0] d,
                         input int ev, input int es);
    for (int i = 0; i < 10; i++) begin
      tick(m[i], d[i]);
      if (i < 9) chk({tag, ".idle"}, val8, 0);
    end
    ce = 1'b0;
    chk({tag, ".valid"}, val8, 1);
    chk({tag, ".vel"}, vel8, ev);
    chk({tag, ".sat"}, sat8, es);
  endtask

  initial begin
    #1 reset = 1'b1;
    #1;
    chk("rst.vel", vel8, 0);
    chk("rst.valid", val8, 0);
    chk("rst.sat", sat8, 0);
    chk("rst.stall", stl8, 0);
    @(posedge clk);
    @(posedge clk);
    #5;
    reset  = 1'b0;
    enable = 1'b1;

    // first sample exactly 10 cycles after release
    run_win("t1", 10'b0, 10'b0, 0, 0);
    chk("t1.stall", stl8, 0);
    run_win("t2.fwd3", 10'b0000001110, 10'b0000001110, 3, 0);
    run_win("t2.empty", 10'b0, 10'b0, 0, 0);
    chk("t2.stall", stl8, 0);
    run_win("t3.rev5", 10'b0000111110, 10'b0000000000, -5, 0);
    run_win("t3.mix", 10'b0000011110, 10'b0000000110, 0, 0);
    run_win("t4.last", 10'b1000000000, 10'b1000000000, 1, 0);
    run_win("t4.first", 10'b0000000001, 10'b0000000001, 1, 0);
    run_win("t5.fwd6", 10'b0001111110, 10'b0001111110, 6, 0);
    chk("t5.vel3", vel3, 3);
    chk("t5.sat3", sat3, 1);
    run_win("t5.empty", 10'b0, 10'b0, 0, 0);
    chk("t5.vel3e", vel3, 0);
    chk("t5.sat3e", sat3, 0);
    chk("t6.stall1", stl8, 0);
    run_win("t6.empty2", 10'b0, 10'b0, 0, 0);
    chk("t6.stall2", stl8, 1);
    chk("t6.stall3", stl3, 1);

    // step mid-window clears stall on the next edge
    for (int i = 0; i < 4; i++) tick(1'b0, 1'b0);
    chk("t6.stallhold", stl8, 1);
    tick(1'b1, 1'b1);
    chk("t6.stallclr", stl8, 0);
    for (int i = 5; i < 10; i++) begin
      tick(1'b0, 1'b0);
      if (i < 9) chk("t6.idle", val8, 0);
    end
    chk("t6.valid", val8, 1);
    chk("t6.vel", vel8, 1);

    // reset at win_cnt==5 after two pulses
    tick(1'b0, 1'b0);
    tick(1'b1, 1'b1);
    tick(1'b1, 1'b1);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    reset = 1'b1;
    #1;
    chk("mrst.vel", vel8, 0);
    chk("mrst.valid", val8, 0);
    chk("mrst.sat", sat8, 0);
    chk("mrst.stall", stl8, 0);
    chk("mrst.vel3", vel3, 0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk("mrst.hold", val8, 0);
    end
    reset = 1'b0;
    run_win("mrst.fresh", 10'b0, 10'b0, 0, 0);

    // enable low mid-window: steps ignored, window restarts on re-enable
    tick(1'b1, 1'b1);
    tick(1'b1, 1'b1);
    enable = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick(1'b1, 1'b1);
      chk("en.valid", val8, 0);
      chk("en.vel", vel8, 0);
    end
    enable = 1'b1;
    run_win("en.fresh", 10'b0000000001, 10'b0000000001, 1, 0);
    tick(1'b0, 1'b0);
    chk("en.pulse1", val8, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
